dds_ctrl_loader: RTL and testbench

- Upstream control stage for the DDS phase accumulator.
- Receives frequency word K and phase word P from a host over a 3-wire serial link (sclk, cs_n, mosi), holds them in shadow registers, and commits them atomically to the K/P outputs that drive the accumulator.
- Guarantees the accumulator never sees a partially written word.

---
 rtl/dds_ctrl_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_dds_ctrl_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_ctrl_loader.sv
// Serial loader for the DDS accumulator control words: receives K/P frames from a host,
// holds them in shadow registers and commits them atomically to the accumulator outputs.
module dds_ctrl_loader #(
    parameter logic [31:0] K_RST      = 32'd0,
    parameter logic [10:0] P_RST      = 11'd0,
    parameter bit          AUTO_APPLY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic [31:0] k_out,
    output logic [10:0] p_out,
    output logic        upd,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned K_W   = 32;
    localparam int unsigned P_W   = 11;
    localparam int unsigned CMD_W = 8;
    localparam int unsigned CNT_W = 6;

    localparam logic [CMD_W-1:0] CMD_K     = 8'h01;
    localparam logic [CMD_W-1:0] CMD_P     = 8'h02;
    localparam logic [CMD_W-1:0] CMD_APPLY = 8'h03;

    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(31);
    localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(15);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_DATA     = 3'd2,
        S_WAIT_END = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       sclk_sync_q;
    logic [2:0]       cs_sync_q;
    logic [1:0]       mosi_sync_q;
    logic             sclk_rise_q;
    logic             cs_fall_q;
    logic             cs_rise_q;
    logic             mosi_bit_q;
    logic [2:0]       sync_vld_q;
    logic             armed_q;

    logic [CNT_W-1:0] cnt_q;
    logic [CMD_W-1:0] cmd_q;
    logic [K_W-1:0]   temp_q;
    logic [K_W-1:0]   k_shadow_q, k_shadow_d;
    logic [P_W-1:0]   p_shadow_q, p_shadow_d;
    logic [K_W-1:0]   k_out_q;
    logic [P_W-1:0]   p_out_q;
    logic             upd_q;
    logic             busy_q;
    logic             frame_err_q;

    logic             shift_cmd_c;
    logic             shift_data_c;
    logic             clr_cnt_c;
    logic             load_k_c;
    logic             load_p_c;
    logic             commit_c;
    logic             err_c;
    logic [CMD_W-1:0] cmd_full_c;
    logic [CNT_W-1:0] data_last_c;

    // Synchronisers plus a registered edge/event stage shared by all three host lines
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            sclk_rise_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_bit_q  <= 1'b0;
            sync_vld_q  <= 3'b000;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_rise_q <= sclk_sync_q[1] & ~sclk_sync_q[2];
            cs_fall_q   <= ~cs_sync_q[1] & cs_sync_q[2];
            cs_rise_q   <= cs_sync_q[1] & ~cs_sync_q[2];
            mosi_bit_q  <= mosi_sync_q[1];
            sync_vld_q  <= {sync_vld_q[1:0], 1'b1};
            // A frame may only start once cs_n has genuinely been seen high since reset
            armed_q     <= armed_q | (sync_vld_q[2] & cs_sync_q[2]);
        end
    end

    assign cmd_full_c  = {cmd_q[CMD_W-2:0], mosi_bit_q};
    assign data_last_c = (cmd_q == CMD_K) ? K_LAST : P_LAST;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cs_n rise takes priority over a coincident sclk edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cs_fall_q && armed_q) state_d = S_CMD;
            end
            S_CMD: begin
                if (cs_rise_q) begin
                    state_d = S_IDLE;
                end else if (sclk_rise_q && (cnt_q == CMD_LAST)) begin
                    case (cmd_full_c)
                        CMD_K, CMD_P: state_d = S_DATA;
                        CMD_APPLY:    state_d = S_WAIT_END;
                        default:      state_d = S_ERR;
                    endcase
                end
            end
            S_DATA: begin
                if (cs_rise_q) begin
                    state_d = S_IDLE;
                end else if (sclk_rise_q && (cnt_q == data_last_c)) begin
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (cs_rise_q) begin
                    state_d = S_IDLE;
                end else if (sclk_rise_q) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (cs_rise_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/strobe decode
    always_comb begin
        shift_cmd_c  = 1'b0;
        shift_data_c = 1'b0;
        clr_cnt_c    = 1'b0;
        load_k_c     = 1'b0;
        load_p_c     = 1'b0;
        commit_c     = 1'b0;
        err_c        = 1'b0;
        case (state_q)
            S_IDLE: begin
                clr_cnt_c = 1'b1;
            end
            S_CMD: begin
                if (cs_rise_q) begin
                    err_c = 1'b1;
                end else if (sclk_rise_q) begin
                    shift_cmd_c = 1'b1;
                    clr_cnt_c   = (cnt_q == CMD_LAST);
                end
            end
            S_DATA: begin
                if (cs_rise_q) begin
                    err_c = 1'b1;
                end else if (sclk_rise_q) begin
                    shift_data_c = 1'b1;
                end
            end
            S_WAIT_END: begin
                if (cs_rise_q) begin
                    load_k_c = (cmd_q == CMD_K);
                    load_p_c = (cmd_q == CMD_P);
                    commit_c = (cmd_q == CMD_APPLY) ||
                               (AUTO_APPLY && ((cmd_q == CMD_K) || (cmd_q == CMD_P)));
                end
            end
            S_ERR: begin
                err_c = cs_rise_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        k_shadow_d = load_k_c ? temp_q : k_shadow_q;
        p_shadow_d = load_p_c ? temp_q[P_W-1:0] : p_shadow_q;
    end

    // Frame datapath, shadows and active outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cmd_q       <= '0;
            temp_q      <= '0;
            k_shadow_q  <= K_RST;
            p_shadow_q  <= P_RST;
            k_out_q     <= K_RST;
            p_out_q     <= P_RST;
            upd_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (clr_cnt_c) begin
                cnt_q <= '0;
            end else if (shift_cmd_c || shift_data_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (shift_cmd_c)  cmd_q  <= cmd_full_c;
            if (shift_data_c) temp_q <= {temp_q[K_W-2:0], mosi_bit_q};
            k_shadow_q <= k_shadow_d;
            p_shadow_q <= p_shadow_d;
            if (commit_c) begin
                k_out_q <= k_shadow_d;
                p_out_q <= p_shadow_d;
            end
            upd_q       <= commit_c;
            busy_q      <= (state_d != S_IDLE);
            frame_err_q <= err_c;
        end
    end

    assign k_out     = k_out_q;
    assign p_out     = p_out_q;
    assign upd       = upd_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_dds_ctrl_loader.sv
// Directed bench for dds_ctrl_loader: one manual-commit instance and one auto-apply
// instance with non-zero reset words, both driven from the same host serial link.
module tb_dds_ctrl_loader;

    localparam logic [31:0] KRA = 32'hA5A5_0001;
    localparam logic [10:0] PRA = 11'h123;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;

    logic [31:0] k0, k1;
    logic [10:0] p0, p1;
    logic        upd0, upd1, busy0, busy1, ferr0, ferr1;

    int vectors    = 0;
    int miscompares = 0;
    int upd0_cnt = 0, upd1_cnt = 0, ferr0_cnt = 0, ferr1_cnt = 0;
    int u0, u1, f0, f1;

    dds_ctrl_loader dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .k_out(k0), .p_out(p0), .upd(upd0), .busy(busy0), .frame_err(ferr0)
    );

    dds_ctrl_loader #(.K_RST(KRA), .P_RST(PRA), .AUTO_APPLY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .k_out(k1), .p_out(p1), .upd(upd1), .busy(busy1), .frame_err(ferr1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd0)  upd0_cnt++;
        if (upd1)  upd1_cnt++;
        if (ferr0) ferr0_cnt++;
        if (ferr1) ferr1_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    // Drops cs_n and clocks out command plus nbits of payload, leaving cs_n low
    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] data, input int nbits);
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
        for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
        wait_clk(4);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic snap();
        u0 = upd0_cnt; u1 = upd1_cnt; f0 = ferr0_cnt; f1 = ferr1_cnt;
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clk(5);
        check("rst_k0", 64'(k0), 64'h0);
        check("rst_p0", 64'(p0), 64'h0);
        check("rst_k1", 64'(k1), 64'(KRA));
        check("rst_p1", 64'(p1), 64'(PRA));
        check("rst_upd_busy_err", 64'({upd0, busy0, ferr0}), 64'h0);
        rst = 1'b0;
        snap();
        wait_clk(20);
        check("idle_k0", 64'(k0), 64'h0);
        check("idle_busy", 64'({busy0, busy1}), 64'h0);
        check("idle_upd", 64'(upd0_cnt + upd1_cnt), 64'h0);
        check("idle_ferr", 64'(ferr0_cnt + ferr1_cnt), 64'h0);

        // K write holds in shadow until APPLY (manual); auto instance commits at once
        snap();
        send_frame(8'h01, 64'h0001_0000, 32);
        check("busy_in_frame", 64'({busy0, busy1}), 64'h3);
        end_frame();
        check("kw_k0_held", 64'(k0), 64'h0);
        check("kw_upd0_none", 64'(upd0_cnt - u0), 64'h0);
        check("kw_k1_auto", 64'(k1), 64'h0001_0000);
        check("kw_upd1_one", 64'(upd1_cnt - u1), 64'h1);
        check("kw_busy_done", 64'({busy0, busy1}), 64'h0);
        snap();
        send_frame(8'h03, 64'h0, 0);
        end_frame();
        check("ap_k0", 64'(k0), 64'h0001_0000);
        check("ap_p0", 64'(p0), 64'h0);
        check("ap_upd0_one", 64'(upd0_cnt - u0), 64'h1);
        check("ap_p1_rst", 64'(p1), 64'(PRA));
        check("ap_ferr_none", 64'((ferr0_cnt - f0) + (ferr1_cnt - f1)), 64'h0);

        // P write keeps only the low 11 bits
        send_frame(8'h02, 64'hF7FF, 16);
        end_frame();
        check("pw_p0_held", 64'(p0), 64'h0);
        check("pw_p1_auto", 64'(p1), 64'h7FF);
        send_frame(8'h03, 64'h0, 0);
        end_frame();
        check("ap_p0_7ff", 64'(p0), 64'h7FF);

        // Short K frame: rejected, shadow untouched
        snap();
        send_frame(8'h01, 64'h1234_5678, 20);
        end_frame();
        check("short_ferr0", 64'(ferr0_cnt - f0), 64'h1);
        check("short_ferr1", 64'(ferr1_cnt - f1), 64'h1);
        check("short_k1", 64'(k1), 64'h0001_0000);
        snap();
        send_frame(8'h03, 64'h0, 0);
        end_frame();
        check("short_ap_k0", 64'(k0), 64'h0001_0000);
        check("short_ap_upd0", 64'(upd0_cnt - u0), 64'h1);

        // Unknown command with trailing clocks
        snap();
        send_frame(8'h55, 64'h0, 32);
        check("err_no_early_ferr", 64'(ferr0_cnt - f0), 64'h0);
        end_frame();
        check("unk_ferr0", 64'(ferr0_cnt - f0), 64'h1);
        check("unk_upd", 64'((upd0_cnt - u0) + (upd1_cnt - u1)), 64'h0);

        // K write with one bit too many
        snap();
        send_frame(8'h01, 64'h1_8765_4321, 33);
        end_frame();
        check("long_ferr0", 64'(ferr0_cnt - f0), 64'h1);
        check("long_k1", 64'(k1), 64'h0001_0000);
        send_frame(8'h03, 64'h0, 0);
        end_frame();
        check("long_ap_k0", 64'(k0), 64'h0001_0000);

        // Commit latency on the auto instance, counted from the cs_n rise
        send_frame(8'h01, 64'hDEAD_BEEF, 32);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lat3_upd1", 64'(upd1), 64'h0);
        check("lat3_k1", 64'(k1), 64'h0001_0000);
        @(posedge clk);
        #1;
        check("lat4_upd1", 64'(upd1), 64'h1);
        check("lat4_k1", 64'(k1), 64'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("lat5_upd1", 64'(upd1), 64'h0);
        check("lat_k0_held", 64'(k0), 64'h0001_0000);
        wait_clk(10);

        // Reset in the middle of a frame, host keeps clocking with cs_n still low
        snap();
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 8; i++) send_bit(i == 7);
        for (int i = 0; i < 16; i++) send_bit(i[0]);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);
        check("mrst_k1", 64'(k1), 64'(KRA));
        check("mrst_p1", 64'(p1), 64'(PRA));
        check("mrst_k0", 64'(k0), 64'h0);
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        wait_clk(4);
        check("mrst_busy", 64'({busy0, busy1}), 64'h0);
        end_frame();
        check("mrst_ferr", 64'((ferr0_cnt - f0) + (ferr1_cnt - f1)), 64'h0);
        check("mrst_upd", 64'((upd0_cnt - u0) + (upd1_cnt - u1)), 64'h0);

        // Fresh frames work after the aborted one
        send_frame(8'h01, 64'hCAFE_F00D, 32);
        end_frame();
        send_frame(8'h03, 64'h0, 0);
        end_frame();
        check("post_k0", 64'(k0), 64'hCAFE_F00D);
        check("post_p0", 64'(p0), 64'h0);
        check("post_k1", 64'(k1), 64'hCAFE_F00D);
        check("post_p1", 64'(p1), 64'(PRA));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
